hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS datapath. It replaces the single-case load-use detector with a complete unit that provides:
- load-use stalls for 1- or 2-cycle data memory;
- EX-stage operand forwarding selects;
- control-hazard flushes on a taken branch or jump resolved in EX;
- a counter-based freeze for multi-cycle MUL/DIV in EX.

It drives the PC enable and the IF/ID, ID/EX and EX/MEM register controls.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_ctrl_mdu_timer.sv | 79 +++++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  // EX operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MUL/DIV occupancy FSM states
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Pipeline register controls driven by the hazard unit
  typedef struct packed {
    logic pc_en;
    logic if_id_wr;
    logic if_id_flush;
    logic id_ex_wr;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// MUL/DIV occupancy timer: holds the pipeline frozen for MDU_LAT-1 cycles
// while a multi-cycle op sits in EX; the op leaves EX on the release edge.
module hazard_mdu_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic mdu_start_E,
  output logic mdu_busy
);

  // Counter preload: the start cycle itself is the first frozen cycle.
  localparam logic [7:0] CNT_LOAD = 8'((MDU_LAT > 32'd1) ? (MDU_LAT - 32'd2) : 32'd0);
  // A single-cycle op never needs a freeze.
  localparam logic       START_EN = (MDU_LAT > 32'd1);

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  // State and counter registers; reset aborts any freeze in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MDU_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter update; start is ignored while already busy.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MDU_IDLE: begin
        if (mdu_start_E && START_EN) begin
          w_state_nxt = MDU_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = MDU_IDLE;
          w_cnt_nxt   = r_cnt;
        end
      end
      MDU_BUSY: begin
        if (r_cnt != 8'd0) begin
          w_state_nxt = MDU_BUSY;
          w_cnt_nxt   = r_cnt - 8'd1;
        end else begin
          w_state_nxt = MDU_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      default: begin
        w_state_nxt = MDU_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Freeze output: high on the start cycle and on every busy cycle but the last.
  always_comb begin
    mdu_busy = 1'b0;
    if (rst) begin
      mdu_busy = 1'b0;
    end else begin
      case (r_state)
        MDU_IDLE: mdu_busy = mdu_start_E && START_EN;
        MDU_BUSY: mdu_busy = (r_cnt != 8'd0);
        default:  mdu_busy = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS datapath: load-use stalls,
// EX forwarding selects, redirect flushes and MUL/DIV freeze.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MDU_LAT  = 32,
  parameter int unsigned FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              use_rs_D,
  input  logic              use_rt_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] dst_E,
  input  logic [REG_AW-1:0] dst_M,
  input  logic [REG_AW-1:0] dst_W,
  input  logic              regwrite_E,
  input  logic              regwrite_M,
  input  logic              regwrite_W,
  input  logic              memtoreg_E,
  input  logic              memtoreg_M,
  input  logic              mdu_start_E,
  input  logic              redirect_E,
  output logic              pc_en_F,
  output logic              if_id_wr,
  output logic              if_id_flush,
  output logic              id_ex_wr,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_a_E,
  output logic [1:0]        fwd_b_E,
  output logic              mdu_busy
);

  localparam logic L_LOAD2 = (LOAD_LAT == 32'd2);
  localparam logic L_FWD   = (FWD_EN != 32'd0);

  // A producer feeds a consumer only if it writes a nonzero register.
  function automatic logic f_match(input logic [REG_AW-1:0] dst, input logic wr,
                                   input logic [REG_AW-1:0] src);
    return wr && (dst == src) && (dst != {REG_AW{1'b0}});
  endfunction

  // Hazard test for one ID source operand.
  function automatic logic f_src_stall(input logic [REG_AW-1:0] src, input logic used);
    logic l_e, l_m, l_w;
    l_e = f_match(dst_E, regwrite_E, src);
    l_m = f_match(dst_M, regwrite_M, src);
    l_w = f_match(dst_W, regwrite_W, src);
    return used && ((l_e && memtoreg_E) ||
                    (L_LOAD2 && l_m && memtoreg_M) ||
                    (!L_FWD && (l_e || l_m || l_w)));
  endfunction

  // Forwarding select for one EX operand; MEM beats WB, loads in MEM cannot forward.
  function automatic logic [1:0] f_fwd_sel(input logic [REG_AW-1:0] src);
    logic [1:0] l_sel;
    if (f_match(dst_M, regwrite_M, src) && !memtoreg_M) begin
      l_sel = FWD_MEM;
    end else if (f_match(dst_W, regwrite_W, src)) begin
      l_sel = FWD_WB;
    end else begin
      l_sel = FWD_RF;
    end
    return l_sel;
  endfunction

  logic       w_mdu_busy;
  logic       w_load_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  pipe_ctrl_t w_ctrl;

  hazard_mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk         (clk),
    .rst         (rst),
    .mdu_start_E (mdu_start_E),
    .mdu_busy    (w_mdu_busy)
  );

  // Load-use (or no-forwarding RAW) stall request from the ID instruction.
  always_comb begin
    w_load_stall = 1'b0;
    if (rst) begin
      w_load_stall = 1'b0;
    end else begin
      w_load_stall = f_src_stall(rs_D, use_rs_D) || f_src_stall(rt_D, use_rt_D);
    end
  end

  // EX operand forwarding selects; all regfile when forwarding is disabled.
  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (L_FWD && !rst) begin
      w_fwd_a = f_fwd_sel(rs_E);
      w_fwd_b = f_fwd_sel(rt_E);
    end else begin
      w_fwd_a = FWD_RF;
      w_fwd_b = FWD_RF;
    end
  end

  // Pipeline control priority: freeze, then redirect, then load-use stall.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (rst) begin
      w_ctrl = CTRL_IDLE;
    end else if (w_mdu_busy) begin
      w_ctrl = CTRL_FREEZE;
    end else if (redirect_E) begin
      w_ctrl = CTRL_REDIRECT;
    end else if (w_load_stall) begin
      w_ctrl = CTRL_LOADUSE;
    end else begin
      w_ctrl = CTRL_IDLE;
    end
  end

  assign pc_en_F      = w_ctrl.pc_en;
  assign if_id_wr     = w_ctrl.if_id_wr;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_wr     = w_ctrl.id_ex_wr;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign ex_mem_flush = w_ctrl.ex_mem_flush;
  assign fwd_a_E      = w_fwd_a;
  assign fwd_b_E      = w_fwd_b;
  assign mdu_busy     = w_mdu_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: three hazard_ctrl configurations share one input set
// and are compared every cycle against a rule-level reference model.
module tb_hazard_ctrl;

  // Configurations: 0 = LOAD_LAT 1, MDU 4, fwd; 1 = LOAD_LAT 2, MDU 32, fwd;
  // 2 = LOAD_LAT 1, MDU 1, no forwarding.
  localparam int LLS [3] = '{1, 2, 1};
  localparam int MLS [3] = '{4, 32, 1};
  localparam int FWS [3] = '{1, 1, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, dst_E, dst_M, dst_W;
  logic       use_rs_D, use_rt_D;
  logic       regwrite_E, regwrite_M, regwrite_W, memtoreg_E, memtoreg_M;
  logic       mdu_start_E, redirect_E;

  // {pc_en, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, mdu_busy}
  logic [2:0][10:0] obs;
  logic [2:0][10:0] samp;

  int checks   = 0;
  int failures = 0;
  int rem [3];
  int busy_cnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(
      .REG_AW   (5),
      .LOAD_LAT (LLS[g]),
      .MDU_LAT  (MLS[g]),
      .FWD_EN   (FWS[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .rs_D         (rs_D),
      .rt_D         (rt_D),
      .use_rs_D     (use_rs_D),
      .use_rt_D     (use_rt_D),
      .rs_E         (rs_E),
      .rt_E         (rt_E),
      .dst_E        (dst_E),
      .dst_M        (dst_M),
      .dst_W        (dst_W),
      .regwrite_E   (regwrite_E),
      .regwrite_M   (regwrite_M),
      .regwrite_W   (regwrite_W),
      .memtoreg_E   (memtoreg_E),
      .memtoreg_M   (memtoreg_M),
      .mdu_start_E  (mdu_start_E),
      .redirect_E   (redirect_E),
      .pc_en_F      (obs[g][10]),
      .if_id_wr     (obs[g][9]),
      .if_id_flush  (obs[g][8]),
      .id_ex_wr     (obs[g][7]),
      .id_ex_flush  (obs[g][6]),
      .ex_mem_flush (obs[g][5]),
      .fwd_a_E      (obs[g][4:3]),
      .fwd_b_E      (obs[g][2:1]),
      .mdu_busy     (obs[g][0])
    );
  end

  // Reference model -------------------------------------------------------
  function automatic logic mt(input logic [4:0] d, input logic w, input logic [4:0] s);
    return w && (d == s) && (d != 5'd0);
  endfunction

  function automatic logic src_stall(input int g, input logic [4:0] s, input logic u);
    logic e, m, w;
    e = mt(dst_E, regwrite_E, s);
    m = mt(dst_M, regwrite_M, s);
    w = mt(dst_W, regwrite_W, s);
    return u && ((e && memtoreg_E) || (LLS[g] == 2 && m && memtoreg_M) ||
                 (FWS[g] == 0 && (e || m || w)));
  endfunction

  function automatic logic [1:0] fsel(input int g, input logic [4:0] s);
    if (FWS[g] == 0) return 2'b00;
    if (mt(dst_M, regwrite_M, s) && !memtoreg_M) return 2'b10;
    if (mt(dst_W, regwrite_W, s)) return 2'b01;
    return 2'b00;
  endfunction

  // rem[g] = cycles the current MUL/DIV still occupies EX (0 = none).
  function automatic logic [10:0] exp_out(input int g);
    logic       frz, ls;
    logic [5:0] c;
    if (rst) return 11'b110100_00_00_0;
    frz = (rem[g] > 1) || (rem[g] == 0 && mdu_start_E && MLS[g] > 1);
    ls  = src_stall(g, rs_D, use_rs_D) || src_stall(g, rt_D, use_rt_D);
    if (frz)             c = 6'b000001;
    else if (redirect_E) c = 6'b111110;
    else if (ls)         c = 6'b000110;
    else                 c = 6'b110100;
    return {c, fsel(g, rs_E), fsel(g, rt_E), frz};
  endfunction

  task automatic model_edge();
    for (int g = 0; g < 3; g++) begin
      if (rst) rem[g] = 0;
      else if (rem[g] == 0) begin
        if (mdu_start_E && MLS[g] > 1) rem[g] = MLS[g] - 1;
      end else rem[g] = rem[g] - 1;
    end
  endtask

  task automatic check_now(input string tag);
    for (int g = 0; g < 3; g++) begin
      logic [10:0] e;
      e = exp_out(g);
      samp[g] = obs[g];
      checks++;
      assert (obs[g] === e) else begin
        failures++;
        $error("FAIL %s dut%0d observed=%b expected=%b", tag, g, obs[g], e);
      end
    end
  endtask

  // One cycle: check mid-cycle, then clock the DUTs and the model together.
  task automatic step(input string tag);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr();
    {rs_D, rt_D, rs_E, rt_E, dst_E, dst_M, dst_W} = '0;
    {use_rs_D, use_rt_D, regwrite_E, regwrite_M, regwrite_W} = '0;
    {memtoreg_E, memtoreg_M, mdu_start_E, redirect_E} = '0;
  endtask

  task automatic set_load_use();
    dst_E = 5'd8; regwrite_E = 1'b1; memtoreg_E = 1'b1;
    rs_D = 5'd8; use_rs_D = 1'b1;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) rem[g] = 0;
    clr();
    rst = 1'b1;
    step("reset");
    step("reset_hold");
    rst = 1'b0;
    step("idle");

    // Load-use: lw $8 moves E -> M -> W while the consumer waits in ID.
    set_load_use();
    step("lu_e_match");
    dst_E = 5'd0; regwrite_E = 1'b0; memtoreg_E = 1'b0;
    dst_M = 5'd8; regwrite_M = 1'b1; memtoreg_M = 1'b1;
    step("lu_m_match");
    dst_M = 5'd0; regwrite_M = 1'b0; memtoreg_M = 1'b0;
    dst_W = 5'd8; regwrite_W = 1'b1;
    step("lu_w_match");
    clr();
    set_load_use();
    dst_E = 5'd0; rs_D = 5'd0;
    step("lu_reg0");

    // Forwarding priority.
    clr();
    dst_M = 5'd9; dst_W = 5'd9; regwrite_M = 1'b1; regwrite_W = 1'b1;
    rs_E = 5'd9; rt_E = 5'd9;
    step("fwd_mem");
    regwrite_M = 1'b0;
    step("fwd_wb");
    regwrite_M = 1'b1; memtoreg_M = 1'b1;
    step("fwd_load_m");

    // Redirect overrides load-use.
    clr();
    set_load_use();
    redirect_E = 1'b1;
    step("redirect_lu");

    // MDU: op held in EX for 4 cycles, redirect mid-freeze, then a second op.
    clr();
    mdu_start_E = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      redirect_E = (i == 1);
      step("mdu_a");
      busy_cnt += int'(samp[0][0]);
    end
    redirect_E = 1'b0;
    checks++;
    assert (busy_cnt === 3) else begin
      failures++;
      $error("FAIL mdu4_len observed=%0d expected=%0d", busy_cnt, 3);
    end
    step("mdu_b2b");
    checks++;
    assert (samp[0][0] === 1'b1) else begin
      failures++;
      $error("FAIL mdu4_b2b observed=%b expected=%b", samp[0][0], 1'b1);
    end
    mdu_start_E = 1'b0;
    for (int i = 0; i < 40; i++) step("mdu_drain");

    // Reset in cycle 2 of a 32-cycle freeze, then a full freeze afterwards.
    mdu_start_E = 1'b1;
    step("rst_c1");
    rst = 1'b1;
    #1;
    check_now("rst_mid");
    step("rst_hold");
    rst = 1'b0;
    mdu_start_E = 1'b0;
    step("rst_rel");
    mdu_start_E = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step("mdu32");
      busy_cnt += int'(samp[1][0]);
    end
    mdu_start_E = 1'b0;
    checks++;
    assert (busy_cnt === 31) else begin
      failures++;
      $error("FAIL mdu32_len observed=%0d expected=%0d", busy_cnt, 31);
    end
    step("mdu32_after");

    // Randomised traffic over a small register space to provoke matches.
    for (int i = 0; i < 400; i++) begin
      rs_D = 5'($urandom_range(3, 0));  rt_D = 5'($urandom_range(3, 0));
      rs_E = 5'($urandom_range(3, 0));  rt_E = 5'($urandom_range(3, 0));
      dst_E = 5'($urandom_range(3, 0)); dst_M = 5'($urandom_range(3, 0));
      dst_W = 5'($urandom_range(3, 0));
      use_rs_D = 1'($urandom_range(1, 0));   use_rt_D = 1'($urandom_range(1, 0));
      regwrite_E = 1'($urandom_range(1, 0)); regwrite_M = 1'($urandom_range(1, 0));
      regwrite_W = 1'($urandom_range(1, 0));
      memtoreg_E = 1'($urandom_range(1, 0)); memtoreg_M = 1'($urandom_range(1, 0));
      mdu_start_E = ($urandom_range(7, 0) == 0);
      redirect_E  = ($urandom_range(5, 0) == 0);
      rst         = ($urandom_range(63, 0) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
